// File: rtl/mse_pkg.sv
// Shared types and sizing helpers for the MSE measurement block.
package mse_pkg;

    // Measurement window control states.
    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StDone
    } mse_state_e;

    localparam int unsigned DefaultDw    = 16;
    localparam int unsigned DefaultNLog2 = 10;

    // Accumulator width: a full window of worst-case squares cannot overflow it.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n_log2);
        return 2 * dw + n_log2;
    endfunction

endpackage

// File: rtl/mse_sq_err.sv
// Two-stage error pipeline: stage 1 forms |y_ref - y_apx|, stage 2 squares it.
module mse_sq_err
    import mse_pkg::*;
#(
    parameter int unsigned DW = DefaultDw
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] y_ref,
    input  logic signed [DW-1:0] y_apx,
    output logic                 sq_valid,
    output logic [2*DW-1:0]      sq,
    output logic [DW:0]          abs_err
);

    logic [DW:0]     diff;
    logic [DW:0]     abs_d;
    logic            v1_q;
    logic [DW:0]     abs1_q;
    logic [2*DW-1:0] abs1_ext;
    logic [2*DW-1:0] sq_d;
    logic            v2_q;
    logic [2*DW-1:0] sq2_q;
    logic [DW:0]     abs2_q;

    // Sign-extend by one bit so the difference can never overflow; magnitude fits unsigned DW+1.
    always_comb begin
        diff  = {y_ref[DW-1], y_ref} - {y_apx[DW-1], y_apx};
        abs_d = diff[DW] ? -diff : diff;
    end

    // Square in 2*DW bits: (2^DW - 1)^2 always fits, so no bits are dropped.
    always_comb begin
        abs1_ext = {{(DW - 1){1'b0}}, abs1_q};
        sq_d     = abs1_ext * abs1_ext;
    end

    // Stage 1 register: valid flag and absolute error.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            abs1_q <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                abs1_q <= abs_d;
            end
        end
    end

    // Stage 2 register: square plus the matching absolute error for the max tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q   <= 1'b0;
            sq2_q  <= '0;
            abs2_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                sq2_q  <= sq_d;
                abs2_q <= abs1_q;
            end
        end
    end

    assign sq_valid = v2_q;
    assign sq       = sq2_q;
    assign abs_err  = abs2_q;

endmodule

// File: rtl/mse_metric.sv
// Windowed sum/mean of squared error, max |error| and nonzero-error count between two streams.
module mse_metric
    import mse_pkg::*;
#(
    parameter int unsigned DW     = DefaultDw,
    parameter int unsigned N_LOG2 = DefaultNLog2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DW-1:0]     y_ref,
    input  logic signed [DW-1:0]     y_apx,
    output logic                     mse_valid,
    input  logic                     mse_ready,
    output logic [2*DW+N_LOG2-1:0]   mse_sum,
    output logic [2*DW-1:0]          mse_mean,
    output logic [DW:0]              max_err,
    output logic [N_LOG2:0]          nz_cnt
);

    localparam int unsigned AccW = acc_width(DW, N_LOG2);
    localparam int unsigned NzW  = N_LOG2 + 1;

    mse_state_e        state_q;
    logic [N_LOG2-1:0] cnt_q;
    logic              drain_q;
    logic              in_ready_q;
    logic              mse_valid_q;
    logic [AccW-1:0]   acc_q;
    logic [DW:0]       max_q;
    logic [NzW-1:0]    nz_q;

    logic              accept;
    logic              last_pair;
    logic              sq_valid;
    logic [2*DW-1:0]   sq;
    logic [DW:0]       abs_err;

    assign accept    = in_valid && in_ready_q;
    assign last_pair = (cnt_q == {N_LOG2{1'b1}});

    mse_sq_err #(
        .DW(DW)
    ) u_sq_err (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept),
        .y_ref    (y_ref),
        .y_apx    (y_apx),
        .sq_valid (sq_valid),
        .sq       (sq),
        .abs_err  (abs_err)
    );

    // Window FSM with registered handshake outputs; DRAIN covers the two pipeline stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            mse_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StAccum;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                    end
                end
                StAccum: begin
                    if (accept) begin
                        cnt_q <= cnt_q + N_LOG2'(1);
                        if (last_pair) begin
                            state_q    <= StDrain;
                            in_ready_q <= 1'b0;
                            drain_q    <= 1'b0;
                        end
                    end
                end
                StDrain: begin
                    if (drain_q) begin
                        state_q     <= StDone;
                        mse_valid_q <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (mse_ready) begin
                        state_q     <= StIdle;
                        mse_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b0;
                    mse_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Stage 3: accumulate squares, track max |error| and count nonzero errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            max_q <= '0;
            nz_q  <= '0;
        end else if (state_q == StIdle && start) begin
            acc_q <= '0;
            max_q <= '0;
            nz_q  <= '0;
        end else if (sq_valid) begin
            acc_q <= acc_q + AccW'(sq);
            if (abs_err > max_q) begin
                max_q <= abs_err;
            end
            if (abs_err != '0) begin
                nz_q <= nz_q + NzW'(1);
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign mse_valid = mse_valid_q;
    assign mse_sum   = acc_q;
    assign mse_mean  = acc_q[AccW-1:N_LOG2];
    assign max_err   = max_q;
    assign nz_cnt    = nz_q;

endmodule

// File: tb/tb_mse_metric.sv
// Directed bench for mse_metric with a 16-sample window and 16-bit samples.
module tb_mse_metric;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] y_ref;
    logic signed [15:0] y_apx;
    logic               mse_valid;
    logic               mse_ready;
    logic [35:0]        mse_sum;
    logic [31:0]        mse_mean;
    logic [16:0]        max_err;
    logic [4:0]         nz_cnt;

    logic signed [15:0] ref_v [16];
    logic signed [15:0] apx_v [16];

    int total = 0;
    int bad   = 0;

    mse_metric #(
        .DW     (16),
        .N_LOG2 (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_ref     (y_ref),
        .y_apx     (y_apx),
        .mse_valid (mse_valid),
        .mse_ready (mse_ready),
        .mse_sum   (mse_sum),
        .mse_mean  (mse_mean),
        .max_err   (max_err),
        .nz_cnt    (nz_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic open_window();
        start = 1'b1;
        step();
        start = 1'b0;
        check("in_ready_after_start", in_ready, 1);
    endtask

    // Present n pairs; optional one-cycle bubble after each, with a start pulse in bubble start_at.
    task automatic feed(input int n, input bit gap, input int start_at);
        int w;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            y_ref    = ref_v[i];
            y_apx    = apx_v[i];
            w        = 0;
            while (!in_ready && w < 50) begin
                step();
                w++;
            end
            if (!in_ready) begin
                check("in_ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            step();
            in_valid = 1'b0;
            if (gap && i < n - 1) begin
                if (i == start_at) start = 1'b1;
                step();
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
    endtask

    // Called one cycle after the last acceptance: result must appear on the third cycle.
    task automatic expect_result(input logic [63:0] s, input logic [63:0] m,
                                 input logic [63:0] mx, input logic [63:0] nz);
        check("mse_valid_lat1", mse_valid, 0);
        step();
        check("mse_valid_lat2", mse_valid, 0);
        step();
        check("mse_valid_lat3", mse_valid, 1);
        check("in_ready_done", in_ready, 0);
        check("mse_sum", mse_sum, s);
        check("mse_mean", mse_mean, m);
        check("max_err", max_err, mx);
        check("nz_cnt", nz_cnt, nz);
    endtask

    task automatic handshake();
        mse_ready = 1'b1;
        step();
        mse_ready = 1'b0;
        check("mse_valid_after_hs", mse_valid, 0);
        check("in_ready_after_hs", in_ready, 0);
    endtask

    initial begin
        int a;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        mse_ready = 1'b0;
        y_ref     = '0;
        y_apx     = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state.
        check("rst_in_ready", in_ready, 0);
        check("rst_mse_valid", mse_valid, 0);
        check("rst_mse_sum", mse_sum, 0);
        check("rst_max_err", max_err, 0);
        check("rst_nz_cnt", nz_cnt, 0);

        // Identical streams: zero error.
        for (int i = 0; i < 16; i++) begin
            ref_v[i] = 16'($urandom);
            apx_v[i] = ref_v[i];
        end
        open_window();
        feed(16, 1'b0, -1);
        expect_result(0, 0, 0, 0);
        handshake();

        // Constant error of +1.
        for (int i = 0; i < 16; i++) begin
            a        = int'($urandom_range(0, 2000)) - 1000;
            apx_v[i] = 16'(a);
            ref_v[i] = 16'(a + 1);
        end
        open_window();
        feed(16, 1'b0, -1);
        expect_result(16, 1, 1, 16);
        handshake();

        // Worst-case error every sample.
        for (int i = 0; i < 16; i++) begin
            ref_v[i] = 16'sh7fff;
            apx_v[i] = 16'sh8000;
        end
        open_window();
        feed(16, 1'b0, -1);
        expect_result(64'd68717379600, 64'd4294836225, 65535, 16);
        handshake();

        // Errors -8..7: sum of squares 344, mean 21, max 8, one zero error.
        for (int i = 0; i < 16; i++) begin
            a        = int'($urandom_range(0, 2000)) - 1000;
            apx_v[i] = 16'(a);
            ref_v[i] = 16'(a + i - 8);
        end
        open_window();
        feed(16, 1'b0, -1);
        expect_result(344, 21, 8, 15);
        // Consumer stalls five cycles; a stray start in DONE must be ignored.
        for (int k = 0; k < 5; k++) begin
            if (k == 2) start = 1'b1;
            step();
            start = 1'b0;
            check("hold_mse_valid", mse_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_mse_sum", mse_sum, 344);
            check("hold_max_err", max_err, 8);
            check("hold_nz_cnt", nz_cnt, 15);
        end
        handshake();

        // Same pattern with a bubble after every pair and a start pulse mid-window.
        open_window();
        feed(16, 1'b1, 7);
        expect_result(344, 21, 8, 15);
        handshake();

        // Reset mid-window after 7 worst-case pairs.
        for (int i = 0; i < 16; i++) begin
            ref_v[i] = 16'sh7fff;
            apx_v[i] = 16'sh8000;
        end
        open_window();
        feed(7, 1'b0, -1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_mse_valid", mse_valid, 0);
        check("midrst_mse_sum", mse_sum, 0);
        check("midrst_max_err", max_err, 0);
        check("midrst_nz_cnt", nz_cnt, 0);
        step();
        step();
        check("midrst_flushed_sum", mse_sum, 0);
        check("midrst_flushed_valid", mse_valid, 0);

        // Fresh window after reset is uncontaminated.
        for (int i = 0; i < 16; i++) begin
            a        = int'($urandom_range(0, 2000)) - 1000;
            apx_v[i] = 16'(a);
            ref_v[i] = 16'(a + 1);
        end
        open_window();
        feed(16, 1'b0, -1);
        expect_result(16, 1, 1, 16);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mse_metric.md
MSE_METRIC -- requirements
Module: mse_metric

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the signed sample width of both input streams.
REQ-002 SHALL have parameter N_LOG2, default 10, meaning the window length as log2 (window = 2^N_LOG2 samples).
REQ-003 SHALL have port clk  in  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  single-cycle pulse that opens a measurement window.
REQ-006 SHALL have port in_valid  in  1  sample pair present.
REQ-007 SHALL have port in_ready  out  1  block accepts a sample pair this cycle.
REQ-008 SHALL have port y_ref  in  DW  signed exact-filter output sample.
REQ-009 SHALL have port y_apx  in  DW  signed approximate-filter output sample.
REQ-010 SHALL have port mse_valid  out  1  result available.
REQ-011 SHALL have port mse_ready  in  1  consumer takes result.
REQ-012 SHALL have port mse_sum  out  2*DW+N_LOG2  unsigned sum of squared errors over the window.
REQ-013 SHALL have port mse_mean  out  2*DW  unsigned mse_sum >> N_LOG2 (truncated).
REQ-014 SHALL have port max_err  out  DW+1  unsigned largest |y_ref - y_apx| in the window.
REQ-015 SHALL have port nz_cnt  out  N_LOG2+1  count of samples with nonzero error.

Function
REQ-016 SHALL implement states IDLE, ACCUM, DRAIN, DONE.
REQ-017 SHALL move IDLE->ACCUM on start, clearing the sample counter, accumulator, max_err and nz_cnt in the same edge.
REQ-018 SHALL ignore start in ACCUM, DRAIN and DONE.
REQ-019 SHALL drive in_ready=1 only in ACCUM; a pair is accepted when in_valid && in_ready.
REQ-020 SHALL compute the error as a DW+1-bit signed difference (no overflow), its absolute value, and a 2*DW-bit unsigned square.
REQ-021 SHALL pipeline the datapath: stage 1 = difference/abs, stage 2 = square, stage 3 = accumulate, max and nonzero update.
REQ-022 SHALL move ACCUM->DRAIN on acceptance of the 2^N_LOG2-th pair, then DRAIN->DONE after exactly 2 cycles, so mse_valid rises 3 cycles after the last accepted pair.
REQ-023 SHALL hold mse_valid=1 with mse_sum, mse_mean, max_err and nz_cnt stable in DONE until mse_valid && mse_ready; DONE->IDLE on that edge.
REQ-024 SHALL tolerate arbitrary in_valid gaps; only accepted pairs count and enter the pipeline.
REQ-025 SHALL not saturate the accumulator; its width makes overflow impossible for a full window of worst-case errors.

Reset
REQ-026 SHALL, on rst=1 at a clock edge (in any state), go to IDLE and zero the pipeline valids, counter, accumulator, max_err and nz_cnt; in_ready=0 and mse_valid=0 in the cycle after.
REQ-027 SHALL give rst priority over start, in_valid and mse_ready in the same cycle.

Structure
REQ-028 SHALL place the state enum, the default DW and an accumulator-width constant/function (2*DW+N_LOG2) in the shared package mse_pkg.
REQ-029 SHALL isolate the difference/abs/square stages in one sub-module, mse_sq_err; FSM, counter and accumulation live in mse_metric.

Verification (N_LOG2=4, DW=16)
REQ-030 SHALL check 16 pairs with y_ref == y_apx (random values) -> mse_sum=0, mse_mean=0, max_err=0, nz_cnt=0.
REQ-031 SHALL check 16 pairs with y_ref - y_apx = 1 -> mse_sum=16, mse_mean=1, max_err=1, nz_cnt=16, mse_valid 3 cycles after the last pair.
REQ-032 SHALL check 16 pairs y_ref=32767, y_apx=-32768 -> mse_sum=68717379600, mse_mean=4294836225, max_err=65535.
REQ-033 SHALL check in_valid toggled every other cycle plus a start pulse mid-window -> the result matches the gap-free run and the start pulse has no effect.
REQ-034 SHALL check mse_ready held low 5 cycles in DONE -> outputs stable and in_ready=0 throughout, IDLE after the handshake.
REQ-035 SHALL check rst asserted after 7 accepted pairs -> IDLE, all outputs 0; a fresh 16-pair window then yields a correct, uncontaminated result.
